// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot/program loader. Streams valid/ready words into the
//               instruction or data memory at consecutive addresses from a
//               latched base, holds the CPU in reset while loading and
//               releases it a fixed number of cycles after the last write.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int RELEASE_DLY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              target_sel,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we_instr,
    output logic              mem_we_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int c_DLY_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
    localparam logic [c_DLY_W-1:0] c_DLY_LOAD = c_DLY_W'(RELEASE_DLY - 1);
    // Two extra bits so base+count itself can never wrap before comparison.
    localparam int c_SUM_W = ADDR_W + 2;
    localparam logic [c_SUM_W-1:0] c_MEM_DEPTH = {2'b01, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_count;
    logic                r_target;
    logic [c_DLY_W-1:0]  r_dly;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_data;
    logic                r_we_instr;
    logic                r_we_data;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_error;
    logic [ADDR_W:0]     r_words_loaded;

    logic [c_SUM_W-1:0]  w_end;
    logic                w_start_ok;
    logic                w_accept;
    logic                w_last;
    logic [ADDR_W:0]     w_last_idx;

    // Start request is legal only for a non-empty load that fits in memory.
    assign w_end      = c_SUM_W'(base_addr) + c_SUM_W'(word_count);
    assign w_start_ok = (word_count != '0) && (w_end <= c_MEM_DEPTH);

    assign in_ready   = (r_state == S_LOAD);
    assign w_accept   = in_valid && in_ready;
    assign w_last_idx = r_count - 1'b1;
    assign w_last     = (r_words_loaded == w_last_idx);

    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign mem_we_instr = r_we_instr;
    assign mem_we_data  = r_we_data;
    assign cpu_rst      = r_cpu_rst;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

    // Loader sequencer: start checks, beat writes, release delay and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_base         <= '0;
            r_count        <= '0;
            r_target       <= 1'b0;
            r_dly          <= '0;
            r_mem_addr     <= '0;
            r_mem_data     <= '0;
            r_we_instr     <= 1'b0;
            r_we_data      <= 1'b0;
            r_cpu_rst      <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
        end else begin
            // Strobes and done are single-cycle pulses.
            r_we_instr <= 1'b0;
            r_we_data  <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base         <= base_addr;
                        r_count        <= word_count;
                        r_target       <= target_sel;
                        r_words_loaded <= '0;
                        r_cpu_rst      <= 1'b1;
                        if (w_start_ok) begin
                            r_error <= 1'b0;
                            r_state <= S_LOAD;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        // A beat offered in the abort cycle is dropped.
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_mem_addr     <= r_base + r_words_loaded[ADDR_W-1:0];
                        r_mem_data     <= in_data;
                        r_we_instr     <= ~r_target;
                        r_we_data      <= r_target;
                        r_words_loaded <= r_words_loaded + 1'b1;
                        if (w_last) begin
                            r_dly   <= c_DLY_LOAD;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_dly == '0) begin
                        r_done    <= 1'b1;
                        r_cpu_rst <= 1'b0;
                        r_state   <= S_RELEASE;
                    end else begin
                        r_dly <= r_dly - 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
